// File: rtl/mux_nx1_scan_pkg.sv
// Shared types and helpers for the registered N:1 scan multiplexer.
package mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Index width for a count of n items; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nx1_scan_if.sv
// Bus bundle between the channel sources/consumer and mux_nx1_scan.
// Optional macro MUX_SEL_ERR_EN adds the sticky sel_err flag.
interface mux_nx1_scan_if #(
  parameter int N = 4,
  parameter int W = 1
);
  import mux_pkg::*;

  localparam int SEL_W = sel_width(N);

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [N*W-1:0]   din;
  logic [W-1:0]     y;
  logic             y_valid;
  logic [SEL_W-1:0] ch;
  logic             wrap;
`ifdef MUX_SEL_ERR_EN
  logic             sel_err;

  modport master (output en, mode, sel, din,
                  input  y, y_valid, ch, wrap, sel_err);
  modport slave  (input  en, mode, sel, din,
                  output y, y_valid, ch, wrap, sel_err);
`else
  modport master (output en, mode, sel, din,
                  input  y, y_valid, ch, wrap);
  modport slave  (input  en, mode, sel, din,
                  output y, y_valid, ch, wrap);
`endif

endinterface

// File: rtl/mux_nx1_scan_counter.sv
// Round-robin scan pointer: holds each channel for DWELL enabled cycles
// and pulses wrap for one cycle when the pointer returns from N-1 to 0.
module scan_counter
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int DWELL = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [SEL_W-1:0] ptr,
  output logic             wrap
);

  localparam int               CNT_W    = sel_width(DWELL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(N - 1);

  logic [CNT_W-1:0] cnt;

  // Dwell counter and pointer advance; clr parks the scan at channel 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt  <= '0;
      ptr  <= '0;
      wrap <= 1'b0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt  <= '0;
        ptr  <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
        wrap <= (ptr == PTR_LAST);
      end else begin
        cnt  <= cnt + 1'b1;
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/mux_nx1_scan.sv
// Registered N:1 multiplexer with manual select and round-robin auto scan.
// Optional macro MUX_SEL_ERR_EN adds a sticky out-of-range select flag.
//
//  state     | meaning
//  ST_IDLE   | after reset, outputs at reset values until first enable
//  ST_MANUAL | capturing the channel chosen by sel
//  ST_SCAN   | capturing the channel chosen by the scan pointer
module mux_nx1_scan
  import mux_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int W     = 1,
  parameter  int DWELL = 4,
  localparam int SEL_W = sel_width(N)
) (
  input  logic           clk,
  input  logic           rst,
  mux_nx1_scan_if.slave  bus
);

  state_t           state, state_nxt;
  logic [W-1:0]     y_nxt;
  logic             valid_nxt;
  logic [SEL_W-1:0] ch_nxt;
  logic [SEL_W-1:0] ptr;
  logic             sel_ok;
  logic             scan_step;
  logic             scan_clr;

  function automatic logic [W-1:0] pick(input logic [N*W-1:0] d,
                                        input logic [SEL_W-1:0] idx);
    pick = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == SEL_W'(k)) pick = d[k*W +: W];
    end
  endfunction

  assign sel_ok    = int'(bus.sel) < N;
  assign scan_step = bus.en && (bus.mode == MODE_SCAN);
  assign scan_clr  = bus.en && (bus.mode == MODE_MANUAL);

  // Pointer is zero whenever scan is entered, so the entering edge captures channel 0.
  scan_counter #(.N(N), .DWELL(DWELL)) u_scan (
    .clk  (clk),
    .rst  (rst),
    .en   (scan_step),
    .clr  (scan_clr),
    .ptr  (ptr),
    .wrap (bus.wrap)
  );

  // Next state and next output values; everything holds while en is low.
  always_comb begin
    state_nxt = state;
    y_nxt     = bus.y;
    valid_nxt = bus.y_valid;
    ch_nxt    = bus.ch;
    if (bus.en) begin
      if (bus.mode == MODE_SCAN) begin
        state_nxt = ST_SCAN;
        y_nxt     = pick(bus.din, ptr);
        valid_nxt = 1'b1;
        ch_nxt    = ptr;
      end else begin
        state_nxt = ST_MANUAL;
        if (sel_ok) begin
          y_nxt     = pick(bus.din, bus.sel);
          valid_nxt = 1'b1;
          ch_nxt    = bus.sel;
        end else begin
          y_nxt     = '0;
          valid_nxt = 1'b0;
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      bus.y       <= '0;
      bus.y_valid <= 1'b0;
      bus.ch      <= '0;
    end else begin
      state       <= state_nxt;
      bus.y       <= y_nxt;
      bus.y_valid <= valid_nxt;
      bus.ch      <= ch_nxt;
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic err_set;

  // Never true for power-of-two N, so the flag stays low there.
  assign err_set = scan_clr && !sel_ok;

  // Sticky until reset.
  always_ff @(posedge clk) begin
    if (rst)          bus.sel_err <= 1'b0;
    else if (err_set) bus.sel_err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Scoreboard bench: two configurations (N=4,W=1,DWELL=2 and N=3,W=4,DWELL=1)
// share control stimulus; a reference model predicts each cycle's outputs.
module tb_mux_nx1_scan;
  localparam int NA = 4, WA = 1, DA = 2;
  localparam int NB = 3, WB = 4, DB = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_nx1_scan_if #(.N(NA), .W(WA)) bus_a ();
  mux_nx1_scan_if #(.N(NB), .W(WB)) bus_b ();

  mux_nx1_scan #(.N(NA), .W(WA), .DWELL(DA)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  mux_nx1_scan #(.N(NB), .W(WB), .DWELL(DB)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  typedef struct {
    int          steps;
    logic [15:0] y;
    logic        vld;
    int          ch;
    logic        wrap;
    logic        err;
  } mdl_t;

  mdl_t ma, mb;
  mdl_t q_a[$];
  mdl_t q_b[$];
  int checks = 0;
  int errors = 0;

  // Scan position is simply the number of scan captures since scan was entered.
  function automatic mdl_t model_step(input mdl_t m, input int n, input int w, input int dwell,
                                      input logic r, input logic e, input logic md,
                                      input int sel, input logic [15:0] din);
    mdl_t o;
    logic [15:0] mask;
    o    = m;
    mask = 16'((1 << w) - 1);
    if (r) begin
      o.steps = 0; o.y = '0; o.vld = 1'b0; o.ch = 0; o.wrap = 1'b0; o.err = 1'b0;
    end else if (!e) begin
      o.wrap = 1'b0;
    end else if (md) begin
      o.ch    = (m.steps / dwell) % n;
      o.y     = (din >> (o.ch * w)) & mask;
      o.vld   = 1'b1;
      o.steps = m.steps + 1;
      o.wrap  = (o.steps % (n * dwell)) == 0;
    end else begin
      o.steps = 0;
      o.wrap  = 1'b0;
      if (sel < n) begin
        o.ch  = sel;
        o.y   = (din >> (sel * w)) & mask;
        o.vld = 1'b1;
      end else begin
        o.y   = '0;
        o.vld = 1'b0;
        o.err = 1'b1;
      end
    end
    return o;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic md, input logic [1:0] s,
                      input logic [3:0] da, input logic [11:0] db);
    rst = r;
    bus_a.en = e;  bus_a.mode = md; bus_a.sel = s; bus_a.din = da;
    bus_b.en = e;  bus_b.mode = md; bus_b.sel = s; bus_b.din = db;
    @(posedge clk);
    ma = model_step(ma, NA, WA, DA, r, e, md, int'(s), {12'd0, da});
    mb = model_step(mb, NB, WB, DB, r, e, md, int'(s), {4'd0, db});
    q_a.push_back(ma);
    q_b.push_back(mb);
    #1;
  endtask

  task automatic scan_n(input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b0, 1'b1, 1'b1, 2'd0, 4'($urandom), 12'($urandom));
  endtask

  // Monitor: compare every registered output one half-cycle after its edge.
  initial begin
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        mdl_t e;
        e = q_a.pop_front();
        chk("a_y",     16'(bus_a.y),       e.y);
        chk("a_valid", 16'(bus_a.y_valid), 16'(e.vld));
        chk("a_ch",    16'(bus_a.ch),      16'(e.ch));
        chk("a_wrap",  16'(bus_a.wrap),    16'(e.wrap));
`ifdef MUX_SEL_ERR_EN
        chk("a_sel_err", 16'(bus_a.sel_err), 16'(e.err));
`endif
      end
      if (q_b.size() > 0) begin
        mdl_t e;
        e = q_b.pop_front();
        chk("b_y",     16'(bus_b.y),       e.y);
        chk("b_valid", 16'(bus_b.y_valid), 16'(e.vld));
        chk("b_ch",    16'(bus_b.ch),      16'(e.ch));
        chk("b_wrap",  16'(bus_b.wrap),    16'(e.wrap));
`ifdef MUX_SEL_ERR_EN
        chk("b_sel_err", 16'(bus_b.sel_err), 16'(e.err));
`endif
      end
    end
  end

  initial begin
    ma = '{0, 16'd0, 1'b0, 0, 1'b0, 1'b0};
    mb = '{0, 16'd0, 1'b0, 0, 1'b0, 1'b0};

    // Reset, then manual captures of channel 2 and channel 0.
    step(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 12'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 4'd0, 12'd0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 12'd0);
    step(1'b0, 1'b1, 1'b0, 2'd2, 4'b0100, 12'h5a3);
    step(1'b0, 1'b1, 1'b0, 2'd0, 4'b0100, 12'h5a3);

    // Full sweep plus one capture past the wrap.
    scan_n(9);

    // Pause mid-sweep with din changing, then resume.
    step(1'b0, 1'b1, 1'b0, 2'd1, 4'($urandom), 12'($urandom));
    scan_n(4);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 2'd0, 4'($urandom), 12'($urandom));
    scan_n(2);

    // Out-of-range select for the 3-channel instance, then back in range.
    step(1'b0, 1'b1, 1'b0, 2'd3, 4'($urandom), 12'($urandom));
    step(1'b0, 1'b1, 1'b0, 2'd1, 4'($urandom), 12'($urandom));
    step(1'b0, 1'b0, 1'b0, 2'd1, 4'($urandom), 12'($urandom));
    step(1'b0, 1'b1, 1'b1, 2'd3, 4'($urandom), 12'($urandom));

    // Reset while scanning, then resume scanning from channel 0.
    step(1'b0, 1'b1, 1'b0, 2'd0, 4'($urandom), 12'($urandom));
    scan_n(5);
    step(1'b1, 1'b1, 1'b1, 2'd0, 4'($urandom), 12'($urandom));
    scan_n(3);

    // Random regression.
    for (int i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) != 0),
           2'($urandom_range(0, 3)),
           4'($urandom), 12'($urandom));
    end

    step(1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 12'd0);
    repeat (2) @(negedge clk);
    #1;
    chk("a_drain", 16'(q_a.size()), 16'd0);
    chk("b_drain", 16'(q_b.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
